// File: rtl/encoder_4x2_pend.sv
// Registered lowest-index-first priority encoder with a sticky pending-request set.
// One pending index is presented at a time under valid/ready and retired on acceptance.
module encoder_4x2_pend #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    input  logic         ready,
    output logic [W-1:0] code,
    output logic         valid,
    output logic [N-1:0] pend
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [W-1:0]   r_code;
    logic [W-1:0]   w_code_next;
    logic           r_valid;
    logic           w_valid_next;
    logic [N-1:0]   r_pend;
    logic [N-1:0]   w_pend_next;
    logic [N-1:0]   w_clr;
    logic [N-1:0]   w_set;
    logic           w_acc;

    // Lowest set index; scanning downward lets the smallest index overwrite last.
    function automatic logic [W-1:0] pe(input logic [N-1:0] x);
        logic [W-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (x[i]) begin
                idx = W'(i);
            end
        end
        return idx;
    endfunction

    assign w_acc = r_valid & ready;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bits
            assign w_clr[gi] = w_acc && (r_code == W'(gi));
            assign w_set[gi] = en && req[gi];
        end
    endgenerate

    // Set is ORed after the clear so a retiring bit that is still requested re-pends.
    assign w_pend_next = (r_pend & ~w_clr) | w_set;

    always_comb begin
        w_state_next = r_state;
        w_code_next  = r_code;
        w_valid_next = r_valid;
        case (r_state)
            IDLE: begin
                if (r_pend != '0) begin
                    w_code_next  = pe(r_pend);
                    w_valid_next = 1'b1;
                    w_state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (w_acc) begin
                    if (w_pend_next != '0) begin
                        w_code_next = pe(w_pend_next);
                    end else begin
                        w_valid_next = 1'b0;
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_code  <= '0;
            r_valid <= 1'b0;
            r_pend  <= '0;
        end else begin
            r_state <= w_state_next;
            r_code  <= w_code_next;
            r_valid <= w_valid_next;
            r_pend  <= w_pend_next;
        end
    end

    assign code  = r_code;
    assign valid = r_valid;
    assign pend  = r_pend;

endmodule
